// File: rtl/reflex_judge_if.sv
// Handshake/status bundle between the reaction-game front end and reflex_judge.
// best_ms exists only when BEST_TIME_EN is defined.
interface reflex_judge_if;
  logic       switch;
  logic       start;
  logic       btn;
  logic       led_go;
  logic       result_valid;
  logic       early;
  logic [9:0] react_ms;
  logic [2:0] wrong_time;
  logic       game_over;
`ifdef BEST_TIME_EN
  logic [9:0] best_ms;
`endif

  modport master (
    output switch, start, btn,
    input  led_go, result_valid, early, react_ms, wrong_time, game_over
`ifdef BEST_TIME_EN
    , input best_ms
`endif
  );

  modport slave (
    input  switch, start, btn,
    output led_go, result_valid, early, react_ms, wrong_time, game_over
`ifdef BEST_TIME_EN
    , output best_ms
`endif
  );
endinterface

// File: rtl/reflex_judge.sv
// reflex_judge: random wait, GO lamp, millisecond reaction timing and miss counting.
// Optional feature macro BEST_TIME_EN adds the best_ms best-reaction register.
module reflex_judge #(
  parameter int          TICK_DIV    = 50000,
  parameter int          WAIT_MIN_MS = 1000,
  parameter logic [10:0] WAIT_MASK   = 11'h7FF,
  parameter int          TIMEOUT_MS  = 999,
  parameter int          MAX_WRONG   = 7
) (
  input logic           clk,
  input logic           rst_n,
  reflex_judge_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [11:0] WAIT_MIN  = 12'(WAIT_MIN_MS);
  localparam logic [11:0] TIMEOUT   = 12'(TIMEOUT_MS);
  localparam logic [2:0]  MAX_W     = 3'(MAX_WRONG);

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
    return (cnt == 3'd7) ? cnt : cnt + 3'd1;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] lfsr_r, presc_r, presc_nxt_s;
  logic [11:0] ms_r, ms_nxt_s, wait_ms_r, wait_nxt_s;
  logic        btn_d_r, rise_s, tick_s;
  logic        led_go_r, led_go_nxt_s, valid_r, early_r, early_nxt_s, over_r;
  logic [9:0]  react_r, react_nxt_s;
  logic [2:0]  wrong_r, wrong_nxt_s;
`ifdef BEST_TIME_EN
  logic [9:0]  best_r, best_nxt_s;
`endif

  assign rise_s = bus.btn & ~btn_d_r;
  assign tick_s = (presc_r == TICK_LAST);

  // Next-state and next-output decode; switch=0 overrides every state.
  always_comb begin
    state_nxt_s  = state_r;
    presc_nxt_s  = presc_r;
    ms_nxt_s     = ms_r;
    wait_nxt_s   = wait_ms_r;
    led_go_nxt_s = led_go_r;
    early_nxt_s  = early_r;
    react_nxt_s  = react_r;
    wrong_nxt_s  = wrong_r;
`ifdef BEST_TIME_EN
    best_nxt_s   = best_r;
`endif
    if (!bus.switch) begin
      state_nxt_s  = IDLE;
      presc_nxt_s  = 16'd0;
      ms_nxt_s     = 12'd0;
      led_go_nxt_s = 1'b0;
      early_nxt_s  = 1'b0;
      react_nxt_s  = 10'd0;
      wrong_nxt_s  = 3'd0;
`ifdef BEST_TIME_EN
      best_nxt_s   = 10'h3FF;
`endif
    end else begin
      if ((state_r == ARMED) || (state_r == GO)) begin
        presc_nxt_s = tick_s ? 16'd0 : presc_r + 16'd1;
        ms_nxt_s    = tick_s ? ms_r + 12'd1 : ms_r;
      end else begin
        presc_nxt_s = presc_r;
      end
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            wait_nxt_s  = WAIT_MIN + {1'b0, lfsr_r[10:0] & WAIT_MASK};
            presc_nxt_s = 16'd0;
            ms_nxt_s    = 12'd0;
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          // A press on the expiry cycle is still early: the rise check comes first.
          if (rise_s) begin
            early_nxt_s = 1'b1;
            react_nxt_s = 10'd0;
            wrong_nxt_s = sat_inc(wrong_r);
            state_nxt_s = DONE;
          end else if (ms_r == wait_ms_r) begin
            led_go_nxt_s = 1'b1;
            presc_nxt_s  = 16'd0;
            ms_nxt_s     = 12'd0;
            state_nxt_s  = GO;
          end else begin
            state_nxt_s = ARMED;
          end
        end
        GO: begin
          if (rise_s) begin
            react_nxt_s  = ms_r[9:0];
            early_nxt_s  = 1'b0;
            led_go_nxt_s = 1'b0;
            state_nxt_s  = DONE;
`ifdef BEST_TIME_EN
            best_nxt_s   = (ms_r[9:0] < best_r) ? ms_r[9:0] : best_r;
`endif
          end else if (ms_r == TIMEOUT) begin
            react_nxt_s  = TIMEOUT[9:0];
            early_nxt_s  = 1'b0;
            wrong_nxt_s  = sat_inc(wrong_r);
            led_go_nxt_s = 1'b0;
            state_nxt_s  = DONE;
          end else begin
            state_nxt_s = GO;
          end
        end
        DONE:    state_nxt_s = (wrong_r == MAX_W) ? OVER : IDLE;
        OVER:    state_nxt_s = OVER;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs; the LFSR free-runs in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r    <= 16'hACE1;
      btn_d_r   <= 1'b0;
      presc_r   <= 16'd0;
      ms_r      <= 12'd0;
      wait_ms_r <= 12'd0;
      led_go_r  <= 1'b0;
      valid_r   <= 1'b0;
      early_r   <= 1'b0;
      react_r   <= 10'd0;
      wrong_r   <= 3'd0;
      over_r    <= 1'b0;
`ifdef BEST_TIME_EN
      best_r    <= 10'h3FF;
`endif
    end else begin
      lfsr_r    <= lfsr_next(lfsr_r);
      btn_d_r   <= bus.btn;
      presc_r   <= presc_nxt_s;
      ms_r      <= ms_nxt_s;
      wait_ms_r <= wait_nxt_s;
      led_go_r  <= led_go_nxt_s;
      valid_r   <= (state_nxt_s == DONE);
      early_r   <= early_nxt_s;
      react_r   <= react_nxt_s;
      wrong_r   <= wrong_nxt_s;
      over_r    <= (state_nxt_s == OVER);
`ifdef BEST_TIME_EN
      best_r    <= best_nxt_s;
`endif
    end
  end

  assign bus.led_go       = led_go_r;
  assign bus.result_valid = valid_r;
  assign bus.early        = early_r;
  assign bus.react_ms     = react_r;
  assign bus.wrong_time   = wrong_r;
  assign bus.game_over    = over_r;
`ifdef BEST_TIME_EN
  assign bus.best_ms      = best_r;
`endif
endmodule

// File: tb/tb_reflex_judge.sv
// Scoreboard bench for reflex_judge with TICK_DIV=4, WAIT_MIN_MS=3, WAIT_MASK=0, TIMEOUT_MS=10, MAX_WRONG=3.
module tb_reflex_judge;
  logic clk = 1'b0;
  logic rst_n;

  reflex_judge_if bus();

  reflex_judge #(
    .TICK_DIV(4), .WAIT_MIN_MS(3), .WAIT_MASK(11'h000), .TIMEOUT_MS(10), .MAX_WRONG(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       early;
    logic [9:0] react;
    logic [2:0] wrong;
    logic [9:0] best;
  } exp_t;

  exp_t       sb_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [9:0] best_m = 10'h3FF;
  logic [2:0] wrong_m = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected result under the hand model: misses bump wrong_time, hits may lower best.
  task automatic push_exp(input logic early, input logic [9:0] react, input logic miss);
    exp_t e;
    if (miss) wrong_m = (wrong_m == 3'd7) ? wrong_m : wrong_m + 3'd1;
    else if (react < best_m) best_m = react;
    e.early = early; e.react = react; e.wrong = wrong_m; e.best = best_m;
    sb_q.push_back(e);
  endtask

  task automatic wait_result;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL result_wait: got no result_valid expected %0d pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: every result_valid cycle must match the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk); #1;
    if (bus.result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_result: got result_valid=1 expected none");
      end else begin
        e = sb_q.pop_front();
        check("early", bus.early, e.early);
        check("react_ms", bus.react_ms, e.react);
        check("wrong_time", bus.wrong_time, e.wrong);
`ifdef BEST_TIME_EN
        check("best_ms", bus.best_ms, e.best);
`endif
      end
    end
  end

  task automatic start_round;
    tick(1); bus.start = 1'b1;
    tick(1); bus.start = 1'b0;
  endtask

  // From ARMED cycle 0: lamp is still dark on cycle 12 (ms==3) and lit on the next.
  task automatic go_edge;
    tick(12); check("led_go_pre", bus.led_go, 1'b0);
    tick(1);  check("led_go_on", bus.led_go, 1'b1);
  endtask

  task automatic hit_round(input int go_cycles, input logic [9:0] react);
    start_round();
    go_edge();
    tick(go_cycles);
    push_exp(1'b0, react, 1'b0);
    bus.btn = 1'b1;
    wait_result();
    check("led_go_off_hit", bus.led_go, 1'b0);
    bus.btn = 1'b0;
    tick(2);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_led_go"}, bus.led_go, 1'b0);
    check({tag, "_early"}, bus.early, 1'b0);
    check({tag, "_react"}, bus.react_ms, 10'd0);
    check({tag, "_wrong"}, bus.wrong_time, 3'd0);
    check({tag, "_over"}, bus.game_over, 1'b0);
    check({tag, "_valid"}, bus.result_valid, 1'b0);
`ifdef BEST_TIME_EN
    check({tag, "_best"}, bus.best_ms, 10'h3FF);
`endif
  endtask

  initial begin
    rst_n = 1'b0; bus.switch = 1'b0; bus.start = 1'b0; bus.btn = 1'b0;
    tick(2);
    check_cleared("reset");
    rst_n = 1'b1;
    tick(2);
    bus.switch = 1'b1;
    tick(2);

    // Hits of 5, 7, 4 ms: GO cycle k reads floor(k/4) ms.
    hit_round(20, 10'd5);
    hit_round(28, 10'd7);
    hit_round(16, 10'd4);

    // Early press 1 ms into the wait.
    start_round();
    tick(4);
    push_exp(1'b1, 10'd0, 1'b1);
    bus.btn = 1'b1;
    wait_result();
    check("led_go_early", bus.led_go, 1'b0);
    bus.btn = 1'b0;
    tick(2);

    // Timeout with the button held since IDLE: no rise, so GO runs the full 10 ms.
    bus.btn = 1'b1;
    tick(2);
    start_round();
    push_exp(1'b0, 10'd10, 1'b1);
    go_edge();
    tick(20);
    check("led_go_mid", bus.led_go, 1'b1);
    wait_result();
    check("led_go_timeout", bus.led_go, 1'b0);
    bus.btn = 1'b0;
    tick(2);

    // Press on the exact expiry cycle is early; third miss ends the game.
    start_round();
    tick(12);
    push_exp(1'b1, 10'd0, 1'b1);
    bus.btn = 1'b1;
    wait_result();
    check("led_go_collision", bus.led_go, 1'b0);
    bus.btn = 1'b0;
    tick(2);
    check("game_over_set", bus.game_over, 1'b1);
    check("wrong_at_over", bus.wrong_time, 3'd3);

    // OVER ignores start and btn.
    start_round();
    tick(20);
    bus.btn = 1'b1; tick(2); bus.btn = 1'b0;
    tick(20);
    check("game_over_hold", bus.game_over, 1'b1);
    check("led_go_over", bus.led_go, 1'b0);

    // switch=0 clears everything on the next edge.
    bus.switch = 1'b0;
    @(posedge clk); #1;
    check_cleared("switch_off");
    tick(2);
    bus.switch = 1'b1;
    best_m = 10'h3FF; wrong_m = 3'd0;
    tick(2);

    // Second start during ARMED must not restart the wait.
    start_round();
    tick(2); bus.start = 1'b1;
    tick(1); bus.start = 1'b0;
    tick(9); check("led_go_rearm_pre", bus.led_go, 1'b0);
    tick(1); check("led_go_rearm_on", bus.led_go, 1'b1);
    tick(8);
    push_exp(1'b0, 10'd2, 1'b0);
    bus.btn = 1'b1;
    wait_result();
    bus.btn = 1'b0;
    tick(2);

    // Async reset in GO drops the lamp at once and abandons the round.
    start_round();
    go_edge();
    tick(5);
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    tick(3);
    rst_n = 1'b1;
    best_m = 10'h3FF; wrong_m = 3'd0;
    tick(30);
    check("led_go_after_rst", bus.led_go, 1'b0);
    check("scoreboard_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
